// File: rtl/lsu.sv
// RV32I load/store unit: decodes a CPU request into one memory access
// and returns a single-cycle response with data or an error flag.
module lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        resp_bus_error,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        mem_signed_read,
    output logic [1:0]  mem_data_width,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    width_q, width_d;
    logic          signed_q, signed_d;
    logic          store_q, store_d;
    logic          mis_q, mis_d;
    logic          ill_q, ill_d;
    logic          berr_q, berr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] addr_sum;
    logic [1:0]  dec_width;
    logic        dec_ill;
    logic        dec_mis;

    assign addr_sum = req_base + req_offset;

    always_comb begin
        dec_width = 2'd0;
        unique case (req_funct3[1:0])
            2'd0:    dec_width = 2'd0;
            2'd1:    dec_width = 2'd1;
            2'd2:    dec_width = 2'd3;
            default: dec_width = 2'd0;
        endcase
        if (req_store) begin
            dec_ill = (req_funct3 > 3'd2);
        end else begin
            dec_ill = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                      (req_funct3 == 3'd7);
        end
        // Illegal encodings win: their width decode is meaningless.
        dec_mis = !dec_ill &&
                  (((req_funct3[1:0] == 2'd1) && addr_sum[0]) ||
                   ((req_funct3[1:0] == 2'd2) && (addr_sum[1:0] != 2'd0)));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        width_d  = width_q;
        signed_d = signed_q;
        store_d  = store_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
        berr_d   = berr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = addr_sum;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'd0;
                    width_d  = dec_width;
                    signed_d = !req_store && !req_funct3[2];
                    store_d  = req_store;
                    mis_d    = dec_mis;
                    ill_d    = dec_ill;
                    berr_d   = 1'b0;
                    state_d  = (dec_ill || dec_mis) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rdata_d = store_q ? 32'd0 : mem_data_out;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    rdata_d = 32'd0;
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            width_q  <= 2'd0;
            signed_q <= 1'b0;
            store_q  <= 1'b0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            berr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            store_q  <= store_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            berr_q   <= berr_d;
            cnt_q    <= cnt_d;
        end
    end

    logic busy;
    assign busy = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_rdata       = resp_valid ? rdata_q : 32'd0;
    assign resp_misaligned  = resp_valid && mis_q;
    assign resp_illegal     = resp_valid && ill_q;
    assign resp_bus_error   = resp_valid && berr_q;
    assign mem_read_enable  = (state_q == S_ISSUE) && !store_q;
    assign mem_write_enable = (state_q == S_ISSUE) && store_q;
    assign mem_address      = busy ? addr_q : 32'd0;
    assign mem_data_in      = busy ? wdata_q : 32'd0;
    assign mem_data_width   = busy ? width_q : 2'd0;
    assign mem_signed_read  = busy && signed_q;

endmodule
